acq_controller: RTL and testbench

ACQ_CONTROLLER -- requirements
Module: acq_controller

---
 rtl/acq_controller.sv | 219 +++++++++++++++++++++
 tb/tb_acq_controller.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_controller.sv
// acq_controller: sequences decimated capture into a sample buffer, then dumps it byte by byte to a UART.
// Optional transmit watchdog is enabled by defining ACQ_CTRL_TIMEOUT_EN.
module acq_controller #(
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_reset,
  input  logic                  i_cmd_sample,
  input  logic                  i_cmd_set_decim,
  input  logic [3:0]            i_cmd_param,
  input  logic                  i_sample_strobe,
  input  logic                  i_tx_done,
  output logic [3:0]            o_decim_factor,
  output logic                  o_dp_reset,
  output logic                  o_buf_wr_en,
  output logic                  o_buf_rd_en,
  output logic [ADDR_WIDTH-1:0] o_buf_addr,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DUMP_RD,
    DUMP_TX,
    DUMP_WAIT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam int                    TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  // Command bit order: [0] reset, [1] set_decim, [2] sample
  logic [2:0] cmd_level;
  logic [2:0] cmd_prev_reg;
  logic [2:0] cmd_edge;

  assign cmd_level = {i_cmd_sample, i_cmd_set_decim, i_cmd_reset};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cmd_edge
    always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
        cmd_prev_reg[gi] <= 1'b0;
      end else begin
        cmd_prev_reg[gi] <= cmd_level[gi];
      end
    end
    assign cmd_edge[gi] = cmd_level[gi] & ~cmd_prev_reg[gi];
  end

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic [3:0]              decim_reg, decim_next;
  logic                    dp_reset_reg, dp_reset_next;
  logic                    wr_en_reg, wr_en_next;
  logic                    rd_en_reg, rd_en_next;
  logic                    tx_start_reg, tx_start_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic                    error_next;
  logic                    last_wr_pending;

`ifdef ACQ_CTRL_TIMEOUT_EN
  logic [TMO_W-1:0]        tmo_reg, tmo_next;
  logic                    error_reg;
`endif

  // The write for the top address is still on the bus; a strobe in that cycle must not start another
  assign last_wr_pending = wr_en_reg && (addr_reg == LAST_ADDR);

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    cnt_next      = cnt_reg;
    decim_next    = decim_reg;
    dp_reset_next = 1'b0;
    wr_en_next    = 1'b0;
    done_next     = 1'b0;
    error_next    = 1'b0;
`ifdef ACQ_CTRL_TIMEOUT_EN
    tmo_next      = tmo_reg;
`endif

    if (cmd_edge[0]) begin
      state_next    = IDLE;
      addr_next     = '0;
      cnt_next      = '0;
      dp_reset_next = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_edge[1]) begin
            decim_next = i_cmd_param;
          end else if (cmd_edge[2]) begin
            state_next = CAPTURE;
            addr_next  = '0;
            cnt_next   = '0;
          end
        end
        CAPTURE: begin
          if (wr_en_reg) begin
            if (addr_reg == LAST_ADDR) begin
              addr_next  = '0;
              state_next = DUMP_RD;
            end else begin
              addr_next = addr_reg + 1'b1;
            end
          end
          if (i_sample_strobe && !last_wr_pending) begin
            if (cnt_reg == 4'd0) begin
              wr_en_next = 1'b1;
              cnt_next   = decim_reg;
            end else begin
              cnt_next = cnt_reg - 1'b1;
            end
          end
        end
        DUMP_RD: begin
          state_next = DUMP_TX;
        end
        DUMP_TX: begin
          state_next = DUMP_WAIT;
`ifdef ACQ_CTRL_TIMEOUT_EN
          tmo_next   = '0;
`endif
        end
        DUMP_WAIT: begin
          if (i_tx_done) begin
            if (addr_reg == LAST_ADDR) begin
              addr_next  = '0;
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              addr_next  = addr_reg + 1'b1;
              state_next = DUMP_RD;
            end
          end
`ifdef ACQ_CTRL_TIMEOUT_EN
          else if (tmo_reg == TMO_LAST) begin
            error_next = 1'b1;
            addr_next  = '0;
            state_next = IDLE;
          end else begin
            tmo_next = tmo_reg + 1'b1;
          end
`endif
        end
        default: begin
          state_next = IDLE;
          addr_next  = '0;
        end
      endcase
    end

    // Strobe-type outputs are registered copies of the state being entered
    rd_en_next    = (state_next == DUMP_RD);
    tx_start_next = (state_next == DUMP_TX);
    busy_next     = (state_next != IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      decim_reg    <= '0;
      dp_reset_reg <= 1'b0;
      wr_en_reg    <= 1'b0;
      rd_en_reg    <= 1'b0;
      tx_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      cnt_reg      <= cnt_next;
      decim_reg    <= decim_next;
      dp_reset_reg <= dp_reset_next;
      wr_en_reg    <= wr_en_next;
      rd_en_reg    <= rd_en_next;
      tx_start_reg <= tx_start_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

`ifdef ACQ_CTRL_TIMEOUT_EN
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      tmo_reg   <= '0;
      error_reg <= 1'b0;
    end else begin
      tmo_reg   <= tmo_next;
      error_reg <= error_next;
    end
  end
  assign o_error = error_reg;
`else
  logic unused_tmo;
  assign unused_tmo = ^{TMO_LAST, error_next};
  assign o_error    = 1'b0;
`endif

  assign o_decim_factor = decim_reg;
  assign o_dp_reset     = dp_reset_reg;
  assign o_buf_wr_en    = wr_en_reg;
  assign o_buf_rd_en    = rd_en_reg;
  assign o_buf_addr     = addr_reg;
  assign o_tx_start     = tx_start_reg;
  assign o_busy         = busy_reg;
  assign o_done         = done_reg;

endmodule

// File: tb/tb_acq_controller.sv
// Testbench for acq_controller: directed and randomized capture/dump rounds checked against
// event-level expectations derived from the decimation and dump rules.
module tb_acq_controller;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 100;

  logic          i_clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_cmd_reset = 1'b0;
  logic          i_cmd_sample = 1'b0;
  logic          i_cmd_set_decim = 1'b0;
  logic [3:0]    i_cmd_param = 4'd0;
  logic          i_sample_strobe = 1'b0;
  logic          i_tx_done = 1'b0;
  logic [3:0]    o_decim_factor;
  logic          o_dp_reset;
  logic          o_buf_wr_en;
  logic          o_buf_rd_en;
  logic [AW-1:0] o_buf_addr;
  logic          o_tx_start;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  always #5 i_clock = ~i_clock;

  acq_controller #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clock         (i_clock),
    .i_reset_n       (i_reset_n),
    .i_cmd_reset     (i_cmd_reset),
    .i_cmd_sample    (i_cmd_sample),
    .i_cmd_set_decim (i_cmd_set_decim),
    .i_cmd_param     (i_cmd_param),
    .i_sample_strobe (i_sample_strobe),
    .i_tx_done       (i_tx_done),
    .o_decim_factor  (o_decim_factor),
    .o_dp_reset      (o_dp_reset),
    .o_buf_wr_en     (o_buf_wr_en),
    .o_buf_rd_en     (o_buf_rd_en),
    .o_buf_addr      (o_buf_addr),
    .o_tx_start      (o_tx_start),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_error         (o_error)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hold_left = 0;

  always @(posedge i_clock) cyc <= cyc + 1;

  // Event log, sampled mid-cycle
  int wr_addr_q[$];
  int wr_sidx_q[$];
  int rd_addr_q[$];
  int rd_cyc_q[$];
  int tx_addr_q[$];
  int tx_cyc_q[$];
  int done_cnt   = 0;
  int dprst_cnt  = 0;
  int err_cnt    = 0;
  int err_cyc    = 0;
  int prev_sidx  = -1;
  int strobe_ctr = 0;

  always @(negedge i_clock) begin
    if (o_buf_wr_en) begin
      wr_addr_q.push_back(int'(o_buf_addr));
      wr_sidx_q.push_back(prev_sidx);
    end
    if (o_buf_rd_en) begin
      rd_addr_q.push_back(int'(o_buf_addr));
      rd_cyc_q.push_back(cyc);
    end
    if (o_tx_start) begin
      tx_addr_q.push_back(int'(o_buf_addr));
      tx_cyc_q.push_back(cyc);
    end
    if (o_done)     done_cnt++;
    if (o_dp_reset) dprst_cnt++;
    if (o_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    prev_sidx = i_sample_strobe ? strobe_ctr : -1;
    if (i_sample_strobe) strobe_ctr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin
          i_cmd_set_decim = 1'b0;
          i_cmd_sample    = 1'b0;
        end
      end
    end
  endtask

  task automatic start_capture(input int n, input string tag);
    i_cmd_param     = 4'(n);
    i_cmd_set_decim = 1'b1;
    step(2);
    i_cmd_set_decim = 1'b0;
    step(1);
    check({tag, "_decim"}, o_decim_factor, n);
    i_cmd_sample = 1'b1;
    step(1);
    i_cmd_sample = 1'b0;
    step(1);
    check({tag, "_busy_cap"}, o_busy, 1);
  endtask

  task automatic run_round(input int n, input int gmin, input int gmax, input int extra,
                           input int hold_at, input int dmin, input int dmax, input bit spur,
                           input string tag);
    int base_s, base_w, base_r, base_t, base_d, base_e, nstr, g, budget, tcyc, d;
    start_capture(n, tag);
    base_s = strobe_ctr;
    base_w = wr_addr_q.size();
    base_r = rd_addr_q.size();
    base_t = tx_addr_q.size();
    base_d = done_cnt;
    base_e = err_cnt;
    nstr   = (DEPTH - 1) * (n + 1) + 1;
    for (int k = 0; k < nstr + extra; k++) begin
      if (k == hold_at) begin
        i_cmd_param     = 4'(n + 5);
        i_cmd_set_decim = 1'b1;
        i_cmd_sample    = 1'b1;
        hold_left       = 4;
      end
      i_sample_strobe = 1'b1;
      step(1);
      i_sample_strobe = 1'b0;
      g = (k < nstr) ? $urandom_range(gmax, gmin) : 0;
      if (k == nstr + extra - 1) g = 0;
      for (int j = 0; j < g; j++) begin
        i_tx_done = spur ? 1'($urandom_range(1, 0)) : 1'b0;
        step(1);
        i_tx_done = 1'b0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      budget = 0;
      while (tx_cyc_q.size() < base_t + i + 1 && budget < 100) begin
        step(1);
        budget++;
      end
      if (tx_cyc_q.size() < base_t + i + 1) begin
        check({tag, "_tx_start_seen"}, 0, 1);
        break;
      end
      tcyc = tx_cyc_q[base_t + i];
      d    = $urandom_range(dmax, dmin);
      while (cyc < tcyc + d) begin
        i_sample_strobe = spur ? 1'($urandom_range(1, 0)) : 1'b0;
        step(1);
        i_sample_strobe = 1'b0;
      end
      i_tx_done = 1'b1;
      step(1);
      i_tx_done = 1'b0;
    end
    step(2);
    check({tag, "_n_wr"}, wr_addr_q.size() - base_w, DEPTH);
    for (int i = 0; i < DEPTH && base_w + i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[base_w + i], i);
      check($sformatf("%s_wr%0d_strobe", tag, i), wr_sidx_q[base_w + i], base_s + i * (n + 1));
    end
    check({tag, "_n_rd"}, rd_addr_q.size() - base_r, DEPTH);
    check({tag, "_n_tx"}, tx_addr_q.size() - base_t, DEPTH);
    for (int i = 0; i < DEPTH && base_r + i < rd_addr_q.size() && base_t + i < tx_addr_q.size(); i++) begin
      check($sformatf("%s_rd%0d_addr", tag, i), rd_addr_q[base_r + i], i);
      check($sformatf("%s_tx%0d_addr", tag, i), tx_addr_q[base_t + i], i);
      check($sformatf("%s_tx%0d_follows_rd", tag, i), tx_cyc_q[base_t + i] - rd_cyc_q[base_r + i], 1);
    end
    check({tag, "_done_pulses"}, done_cnt - base_d, 1);
    check({tag, "_err_pulses"}, err_cnt - base_e, 0);
    check({tag, "_busy_end"}, o_busy, 0);
    check({tag, "_addr_end"}, o_buf_addr, 0);
    check({tag, "_decim_kept"}, o_decim_factor, n);
  endtask

  initial begin : main
    int base_w, base_d, base_p, base_e, budget, tcyc;

    // Power-on reset
    i_reset_n = 1'b0;
    step(3);
    i_reset_n = 1'b1;
    step(1);
    check("rst_decim", o_decim_factor, 0);
    check("rst_busy", o_busy, 0);
    check("rst_addr", o_buf_addr, 0);
    check("rst_strobes", {o_dp_reset, o_buf_wr_en, o_buf_rd_en, o_tx_start, o_done, o_error}, 0);

    // Directed: decim 2, 48 strobes, tx_done 5 cycles after each tx_start
    run_round(2, 2, 2, 2, -1, 5, 5, 1'b0, "dir");

    // Commands held during capture are ignored
    run_round(1, 1, 1, 0, 5, 3, 3, 1'b0, "hold");

    // Randomized rounds with stray strobes / tx_done outside their states
    for (int r = 0; r < 4; r++) begin
      run_round($urandom_range(3, 0), 0, 3, 0, ($urandom_range(1, 0) != 0) ? 3 : -1,
                1, 8, 1'b1, $sformatf("rnd%0d", r));
    end

    // Reset command after 7 writes
    start_capture(1, "abort");
    base_w = wr_addr_q.size();
    base_d = done_cnt;
    base_p = dprst_cnt;
    for (int k = 0; k < 13; k++) begin
      i_sample_strobe = 1'b1;
      step(1);
      i_sample_strobe = 1'b0;
      step(1);
    end
    step(2);
    check("abort_n_wr", wr_addr_q.size() - base_w, 7);
    i_cmd_reset = 1'b1;
    step(1);
    i_cmd_reset = 1'b0;
    step(3);
    check("abort_dp_reset_cycles", dprst_cnt - base_p, 1);
    check("abort_busy", o_busy, 0);
    check("abort_addr", o_buf_addr, 0);
    check("abort_decim", o_decim_factor, 1);
    check("abort_no_done", done_cnt - base_d, 0);
    for (int k = 0; k < 4; k++) begin
      i_sample_strobe = 1'b1;
      step(1);
      i_sample_strobe = 1'b0;
      step(1);
    end
    check("idle_strobe_no_wr", wr_addr_q.size() - base_w, 7);

    // Simultaneous edges: reset beats everything, set_decim beats sample
    base_p = dprst_cnt;
    i_cmd_param     = 4'd9;
    i_cmd_reset     = 1'b1;
    i_cmd_set_decim = 1'b1;
    i_cmd_sample    = 1'b1;
    step(1);
    i_cmd_reset     = 1'b0;
    i_cmd_set_decim = 1'b0;
    i_cmd_sample    = 1'b0;
    step(2);
    check("prio_rst_pulse", dprst_cnt - base_p, 1);
    check("prio_rst_decim", o_decim_factor, 1);
    check("prio_rst_busy", o_busy, 0);
    i_cmd_param     = 4'd6;
    i_cmd_set_decim = 1'b1;
    i_cmd_sample    = 1'b1;
    step(3);
    i_cmd_set_decim = 1'b0;
    i_cmd_sample    = 1'b0;
    step(2);
    check("prio_decim_load", o_decim_factor, 6);
    check("prio_decim_busy", o_busy, 0);

    // Stalled transmitter
    start_capture(0, "stall");
    base_d = done_cnt;
    base_e = err_cnt;
    base_p = tx_cyc_q.size();
    for (int k = 0; k < DEPTH; k++) begin
      i_sample_strobe = 1'b1;
      step(1);
      i_sample_strobe = 1'b0;
    end
    budget = 0;
    while (tx_cyc_q.size() == base_p && budget < 50) begin
      step(1);
      budget++;
    end
    check("stall_tx_start_seen", tx_cyc_q.size() - base_p, 1);
    tcyc = (tx_cyc_q.size() > base_p) ? tx_cyc_q[base_p] : cyc;
    step(TMO + 50);
`ifdef ACQ_CTRL_TIMEOUT_EN
    check("tmo_error_cycles", err_cnt - base_e, 1);
    check("tmo_error_latency", err_cyc - tcyc, TMO + 1);
    check("tmo_busy", o_busy, 0);
    check("tmo_addr", o_buf_addr, 0);
    check("tmo_no_done", done_cnt - base_d, 0);
`else
    check("stall_no_error", err_cnt - base_e, 0);
    check("stall_still_busy", o_busy, 1);
    i_cmd_reset = 1'b1;
    step(1);
    i_cmd_reset = 1'b0;
    step(2);
    check("stall_abort_busy", o_busy, 0);
    check("stall_abort_addr", o_buf_addr, 0);
    check("stall_abort_no_done", done_cnt - base_d, 0);
    check("stall_abort_no_error", err_cnt - base_e, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
